// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync_fifo family.
package sync_fifo_pkg;

    // Read-path flavour: registered output (STD) or show-ahead head word (FWFT).
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Bit positions inside the sticky error vector.
    localparam int ERR_W   = 2;
    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;

    // Address width for a power-of-two depth.
    function automatic int fifo_addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately never reset.
module fifo_mem_2p
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    localparam int ADDR_W = fifo_addr_w(DEPTH)
)(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count, flush,
// sticky overflow/underflow flags and a selectable STD/FWFT read path.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int         WIDTH     = 16,
    parameter int         DEPTH     = 16,
    parameter int         AF_THRESH = DEPTH - 2,
    parameter int         AE_THRESH = 2,
    parameter fifo_mode_e MODE      = FIFO_STD
)(
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   fifo_flush,
    input  logic                   fifo_clr_err,
    input  logic                   fifo_write,
    input  logic [WIDTH-1:0]       fifo_data_in,
    input  logic                   fifo_read,
    output logic [WIDTH-1:0]       fifo_data_out,
    output logic                   fifo_rd_valid,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic                   fifo_almost_full,
    output logic                   fifo_almost_empty,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   fifo_overflow,
    output logic                   fifo_underflow
);

    localparam int ADDR_W = fifo_addr_w(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0]    r_wr_ptr;
    logic [ADDR_W:0]    r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_af;
    logic               r_ae;
    logic [ERR_W-1:0]   r_err;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_mem_we;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [ERR_W-1:0]   w_err_set;
    logic [WIDTH-1:0]   w_rdata;

    // Pointer-derived full/empty on the pre-edge state; these gate acceptance.
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign w_wr_acc    = fifo_write && !w_full;
    assign w_rd_acc    = fifo_read  && !w_empty;
    assign w_count_nxt = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);

    // Memory never sees a write in a reset or flush cycle.
    assign w_mem_we = w_wr_acc && !fifo_flush && !rst_;

    assign w_err_set[ERR_OVF] = fifo_write && w_full;
    assign w_err_set[ERR_UDF] = fifo_read  && w_empty;

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (fifo_data_in),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    // Pointers, occupancy and status flags; flags are all registered from
    // the same next count so they always agree with each other.
    always_ff @(posedge clk) begin
        if (rst_ || fifo_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            r_af    <= (w_count_nxt >= CNT_W'(AF_THRESH));
            r_ae    <= (w_count_nxt <= CNT_W'(AE_THRESH));
        end
    end

    // Sticky errors: a new set event beats a same-cycle clear; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst_) begin
            r_err <= '0;
        end else begin
            r_err <= (r_err & ~{ERR_W{fifo_clr_err}}) | w_err_set;
        end
    end

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            // Head word shown directly; zero while empty so reset output is clean.
            assign fifo_data_out = r_empty ? '0 : w_rdata;
            assign fifo_rd_valid = !r_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_dout;
            logic             r_vld;

            // Registered read: data lands one cycle after the accepted read.
            always_ff @(posedge clk) begin
                if (rst_) begin
                    r_dout <= '0;
                    r_vld  <= 1'b0;
                end else if (fifo_flush) begin
                    r_vld  <= 1'b0;
                end else begin
                    r_vld <= w_rd_acc;
                    if (w_rd_acc) r_dout <= w_rdata;
                end
            end

            assign fifo_data_out = r_dout;
            assign fifo_rd_valid = r_vld;
        end
    endgenerate

    assign fifo_full         = r_full;
    assign fifo_empty        = r_empty;
    assign fifo_almost_full  = r_af;
    assign fifo_almost_empty = r_ae;
    assign fifo_count        = r_count;
    assign fifo_overflow     = r_err[ERR_OVF];
    assign fifo_underflow    = r_err[ERR_UDF];

endmodule
